// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and flag bundle for the EX-stage ALU.
package alu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SLL  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_SRL  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SRA  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_SLTU = 4'b1000;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_NOR  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;

  // done marks the cycle whose step is the last one; acc is final on the next cycle
  assign done    = busy && (cnt == CNT_W'(WIDTH - 1));
  assign product = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready on both sides, a one-entry output buffer
// and an iterative multiply; single-cycle ops complete at the accepting edge.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int OP_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   reg1,
  input  logic [WIDTH-1:0]   reg2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   o1,
  output logic               zero,
  output logic               ovf,
  output logic               illegal
);

  state_t state, state_nx;

  logic             rdy_en;
  logic             out_free;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic             ld_alu;
  logic             ld_mul;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res;
  flags_t           fl_c;
  flags_t           fl_q;

  // rdy_en keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign out_free = !out_valid || out_ready;
  assign in_ready = rdy_en && (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_W'(OP_MUL));

  always_comb begin
    sum          = reg1 + reg2;
    diff         = reg1 - reg2;
    res          = '0;
    fl_c.ovf     = 1'b0;
    fl_c.illegal = 1'b0;
    case (op)
      OP_W'(OP_AND):  res = reg1 & reg2;
      OP_W'(OP_OR):   res = reg1 | reg2;
      OP_W'(OP_ADD): begin
        res      = sum;
        fl_c.ovf = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
      end
      OP_W'(OP_SUB): begin
        res      = diff;
        fl_c.ovf = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (diff[WIDTH-1] != reg1[WIDTH-1]);
      end
      OP_W'(OP_SLL):  res = reg1 << shamt;
      OP_W'(OP_SRL):  res = reg1 >> shamt;
      OP_W'(OP_SRA):  res = $signed(reg1) >>> shamt;
      OP_W'(OP_SLT):  res = WIDTH'($signed(reg1) < $signed(reg2));
      OP_W'(OP_SLTU): res = WIDTH'(reg1 < reg2);
      OP_W'(OP_XOR):  res = reg1 ^ reg2;
      OP_W'(OP_NOR):  res = ~(reg1 | reg2);
      OP_W'(OP_MUL):  res = '0;
      default:        fl_c.illegal = 1'b1;
    endcase
    fl_c.zero = (res == '0);
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (reg1),
    .b       (reg2),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    ld_alu    = 1'b0;
    ld_mul    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_nx  = MUL;
          end else begin
            ld_alu = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done) state_nx = DONE;
      end
      DONE: begin
        // product waits here until the output buffer can take it
        if (out_free) begin
          ld_mul   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      o1        <= '0;
      fl_q      <= '0;
    end else if (ld_alu) begin
      out_valid <= 1'b1;
      o1        <= res;
      fl_q      <= fl_c;
    end else if (ld_mul) begin
      out_valid    <= 1'b1;
      o1           <= mul_prod;
      fl_q.zero    <= (mul_prod == '0);
      fl_q.ovf     <= 1'b0;
      fl_q.illegal <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign zero    = fl_q.zero;
  assign ovf     = fl_q.ovf;
  assign illegal = fl_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases, back-pressure, mid-multiply reset, random ops.
module tb_alu_pipe;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [3:0]    op = '0;
  logic [W-1:0]  reg1 = '0;
  logic [W-1:0]  reg2 = '0;
  logic [4:0]    shamt = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  o1;
  logic          zero;
  logic          ovf;
  logic          illegal;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .SHAMT_W(5), .OP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .reg1      (reg1),
    .reg2      (reg2),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o1        (o1),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  typedef struct {
    logic [31:0] o1;
    logic        zero;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          rand_rdy = 1'b0;
  logic        rdy_force = 1'b1;
  logic        held = 1'b0;
  logic [31:0] held_o1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] s);
    exp_t   r;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint t;
    logic [63:0] p;
    r.o1 = '0; r.ovf = 1'b0; r.ill = 1'b0;
    case (o)
      4'd0:  r.o1 = a & b;
      4'd1:  r.o1 = a | b;
      4'd2:  begin t = sa + sb; r.o1 = t[31:0]; r.ovf = (t > 2147483647) || (t < -64'sd2147483648); end
      4'd6:  begin t = sa - sb; r.o1 = t[31:0]; r.ovf = (t > 2147483647) || (t < -64'sd2147483648); end
      4'd3:  r.o1 = a << s;
      4'd4:  r.o1 = a >> s;
      4'd5:  begin t = sa >>> s; r.o1 = t[31:0]; end
      4'd7:  r.o1 = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r.o1 = (a < b) ? 32'd1 : 32'd0;
      4'd9:  r.o1 = a ^ b;
      4'd10: r.o1 = ~(a | b);
      4'd11: begin p = {32'd0, a} * {32'd0, b}; r.o1 = p[31:0]; end
      default: r.ill = 1'b1;
    endcase
    r.zero = (r.o1 == 0);
    return r;
  endfunction

  // Monitor: pops on every output handshake, and checks held outputs stay put
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_o1", o1, held_o1);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected: got o1=%0h expected no output", o1);
        end else begin
          e = sbq.pop_front();
          chk("sb_o1", o1, e.o1);
          chk("sb_zero", zero, e.zero);
          chk("sb_ovf", ovf, e.ovf);
          chk("sb_illegal", illegal, e.ill);
        end
      end
      held    = out_valid && !out_ready;
      held_o1 = o1;
    end
  end

  // Must be called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] s);
    bit ok = 1'b0;
    op = o; reg1 = a; reg2 = b; shamt = s; in_valid = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(model(o, a, b, s));
        ok = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got no in_ready expected accept of op %0h", o);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0 && !out_valid) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  int n;
  int t_prev;

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_o1", o1, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", in_ready, 1);

    // single-cycle ops and corners
    send(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
    chk("add_latency_valid", out_valid, 1);
    chk("add_o1", o1, 32'h80000000);
    chk("add_ovf", ovf, 1);
    chk("add_zero", zero, 0);
    send(4'b0110, 32'd5, 32'd5, 5'd0);
    send(4'b0101, 32'h80000000, 32'h0, 5'd4);
    send(4'b0100, 32'h80000000, 32'h0, 5'd4);
    send(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0);
    send(4'b1000, 32'hFFFFFFFF, 32'h1, 5'd0);
    send(4'b1111, 32'h1234, 32'h5678, 5'd3);
    send(4'b0110, 32'h80000000, 32'h1, 5'd0);
    send(4'b0011, 32'h0000000F, 32'h0, 5'd28);
    send(4'b1010, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd0);
    drain();

    // multiply latency with in_ready held low
    send(4'b1011, 32'hFFFFFFFF, 32'd3, 5'd0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
      chk("mul_in_ready_low", in_ready, 0);
    end
    chk("mul_latency", n, 33);
    chk("mul_o1", o1, 32'hFFFFFFFD);
    @(posedge clk); #1;
    drain();

    // back-pressure then a 1/clk stream
    rdy_force = 1'b0;
    @(posedge clk); #1;
    send(4'b0010, 32'd1, 32'd2, 5'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_o1", o1, 32'd3);
    end
    rdy_force = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send(4'b0010, 32'(i + 1), 32'd10, 5'd0);
      if (i > 0) chk("stream_rate", cyc - t_prev, 1);
      t_prev = cyc;
    end
    drain();

    // reset in the middle of a multiply
    send(4'b1011, 32'h12345678, 32'h9ABC, 5'd0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_o1", o1, 0);
    chk("mrst_flags", {zero, ovf, illegal}, 0);
    chk("mrst_in_ready", in_ready, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'b1011, 32'd7, 32'd6, 5'd0);
    send(4'b0110, 32'd100, 32'd58, 5'd0);
    drain();

    // random ops with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    drain();
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
